// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: default sizing, counter width, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 20000;
  localparam int GAP_DEF     = 2;
  localparam int CNT_W       = 16;

  // Encoded as plain constants so older code can compare raw state bits.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: first requester found searching upward from last_grant+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; gnt is all-zero when no requester is active.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  // Scan every candidate once, starting just after the previous winner.
  always_comb begin
    int   cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters with round-robin grant, timeout and inter-frame gap.
// Latency: byte accepted in cycle N produces tx_start in cycle N+1.
// Backpressure: req_ready is offered only in IDLE, to the single round-robin winner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int IW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_err
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    last_grant;
  logic [NREQ-1:0]  win_gnt;
  logic [IW-1:0]    win_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (win_gnt),
    .idx        (win_idx)
  );

  // Ready is gated by reset so nothing looks accepted while reset is held.
  assign req_ready = (state == ST_IDLE && !reset) ? win_gnt : '0;
  assign tx_start  = (state == ST_START);
  assign busy      = (state != ST_IDLE);

  // Frame sequencing: accept, start pulse, wait for done or timeout, then idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last_grant  <= IW'(NREQ - 1);
      tx_data     <= 8'h00;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            tx_data    <= req_data[int'(win_idx)*8 +: 8];
            grant_id   <= win_idx;
            last_grant <= win_idx;
            state      <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done takes priority over a coincident timeout expiry.
          if (tx_done) begin
            cnt   <= '0;
            state <= ST_GAP;
          end else if (32'(cnt) == 32'(TIMEOUT - 1)) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          // GAP of 0 or 1 both leave after a single cycle.
          if (32'(cnt) + 32'd1 >= 32'(GAP)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
